bit_word_deserializer: RTL and testbench

Downstream consumer of the PLL-clocked data capture stage. Takes the registered single-bit data stream and its enable, assembles WORD_W-bit words and queues them in a small first-word-fall-through FIFO with a valid/ready output. A synchronous half-rate sampling mode replaces the ripple-divided clock with a clock enable, so both sampling rates stay in one clock domain.

---
 rtl/bit_word_deser_pkg.sv | 11 +
 rtl/bit_word_deserializer_if.sv | 17 +
 rtl/bit_word_deserializer_fifo.sv | 70 +++++++
 rtl/bit_word_deserializer.sv | 78 +++++++
 tb/tb_bit_word_deserializer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/bit_word_deser_pkg.sv
// rtl/bit_word_deser_pkg.sv - shared defaults and width helper for the bit-to-word deserializer
package bit_word_deser_pkg;

  localparam int WORD_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bit_word_deserializer_if.sv
// rtl/bit_word_deserializer_if.sv - word output handshake between deserializer and consumer
interface bit_word_deserializer_if
  import bit_word_deser_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) ();

  logic [WORD_W-1:0]              word_o;
  logic                           valid_o;
  logic                           ready_i;
  logic [level_w(FIFO_DEPTH)-1:0] level_o;

  modport master (output word_o, output valid_o, output level_o, input ready_i);
  modport slave  (input word_o, input valid_o, input level_o, output ready_i);

endinterface

// File: rtl/bit_word_deserializer_fifo.sv
// rtl/bit_word_deserializer_fifo.sv - first-word-fall-through word FIFO with registered head and flush
module sync_fifo_fwft
  import bit_word_deser_pkg::*;
#(
  parameter int WIDTH = WORD_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head,
  output logic                      valid,
  output logic                      full,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic             push_ok, pop_ok;
  logic [LVL_W-1:0] level_after_pop, level_nxt;

  assign full            = (level == LVL_W'(DEPTH));
  assign pop_ok          = pop && valid;
  assign push_ok         = push && (!full || pop_ok);
  assign rd_nxt          = rd_ptr + PTR_W'(pop_ok);
  assign level_after_pop = level - LVL_W'(pop_ok);
  assign level_nxt       = level_after_pop + LVL_W'(push_ok);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Head is pre-loaded with the next entry so word_o is a register, not a mem read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_nxt;
      level  <= level_nxt;
      valid  <= (level_nxt != '0);
      if (level_after_pop != '0) begin
        head <= mem[rd_nxt];
      end else if (push_ok) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/bit_word_deserializer.sv
// rtl/bit_word_deserializer.sv - serial bit capture with optional half-rate enable, word assembly and FIFO output
module bit_word_deserializer
  import bit_word_deser_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    data_i,
  input  logic                    enable_i,
  input  logic                    half_rate_i,
  input  logic                    clear_i,
  bit_word_deserializer_if.master word_if,
  output logic                    overflow_o
);

  localparam int CNT_W = $clog2(WORD_W);

  logic              phase;
  logic              sample_ce, capture, last_bit, push, pop, fifo_full;
  logic [WORD_W-1:0] shift_q, shift_nxt;
  logic [CNT_W-1:0]  bit_cnt;

  assign sample_ce = !half_rate_i || phase;
  assign capture   = sample_ce && enable_i;
  assign last_bit  = (bit_cnt == CNT_W'(WORD_W - 1));
  assign shift_nxt = MSB_FIRST ? {shift_q[WORD_W-2:0], data_i} : {data_i, shift_q[WORD_W-1:1]};
  assign push      = capture && last_bit && !clear_i;
  assign pop       = word_if.valid_o && word_if.ready_i;

  // Phase free-runs so half-rate sampling stays aligned to reset, independent of clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
    end else begin
      phase <= !phase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (capture) begin
        shift_q <= shift_nxt;
        bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      end
      if (push && fifo_full && !pop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clear_i),
    .push      (push),
    .push_data (shift_nxt),
    .pop       (pop),
    .head      (word_if.word_o),
    .valid     (word_if.valid_o),
    .full      (fifo_full),
    .level     (word_if.level_o)
  );

endmodule

// File: tb/tb_bit_word_deserializer.sv
// tb/tb_bit_word_deserializer.sv - directed checks of word assembly, half-rate, FIFO overflow, clear and reset
module tb_bit_word_deserializer;
  import bit_word_deser_pkg::*;

  localparam int W = WORD_W_DEF;
  localparam int D = FIFO_DEPTH_DEF;

  logic clk = 1'b0;
  logic rst_n, data, enable, half_rate, clear, ready;
  logic ovf_m, ovf_l;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit_word_deserializer_if #(.WORD_W(W), .FIFO_DEPTH(D)) if_m ();
  bit_word_deserializer_if #(.WORD_W(W), .FIFO_DEPTH(D)) if_l ();

  assign if_m.ready_i = ready;
  assign if_l.ready_i = ready;

  bit_word_deserializer #(.WORD_W(W), .FIFO_DEPTH(D), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .data_i(data), .enable_i(enable), .half_rate_i(half_rate),
    .clear_i(clear), .word_if(if_m), .overflow_o(ovf_m)
  );

  bit_word_deserializer #(.WORD_W(W), .FIFO_DEPTH(D), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .data_i(data), .enable_i(enable), .half_rate_i(half_rate),
    .clear_i(clear), .word_if(if_l), .overflow_o(ovf_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    data   = b;
    enable = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] v;
  logic [7:0] got;
  logic [7:0] exp_q [4];
  int         seen, seen_at;

  initial begin
    rst_n = 1'b0; data = 1'b0; enable = 1'b0; half_rate = 1'b0; clear = 1'b0; ready = 1'b1;
    tick();
    tick();
    check("rst_word", if_m.word_o, 0);
    check("rst_valid", if_m.valid_o, 0);
    check("rst_level", if_m.level_o, 0);
    check("rst_ovf", ovf_m, 0);
    rst_n = 1'b1;

    // 1,0,1,0,0,1,0,1 -> A5 in both bit orders, valid for one cycle
    v = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    check("a5_pre_valid", if_m.valid_o, 0);
    send_bit(v[0]);
    check("a5_valid", if_m.valid_o, 1);
    check("a5_word_msb", if_m.word_o, 8'hA5);
    check("a5_word_lsb", if_l.word_o, 8'hA5);
    check("a5_level", if_m.level_o, 1);
    idle(1);
    check("a5_valid_drop", if_m.valid_o, 0);
    check("a5_level_drop", if_m.level_o, 0);

    // 1,1,0,0,0,0,0,0 -> C0 msb-first, 03 lsb-first
    send_byte(8'hC0);
    check("c0_word_msb", if_m.word_o, 8'hC0);
    check("c0_word_lsb", if_l.word_o, 8'h03);
    idle(1);

    // Half rate from reset: samples on odd edges; data on even edges is junk 0
    do_reset();
    half_rate = 1'b1;
    seen = 0; seen_at = -1; got = 8'h00;
    for (int k = 0; k < 18; k++) begin
      data   = (k % 2 == 1);
      enable = (k < 16);
      tick();
      if (if_m.valid_o) begin
        seen++;
        if (seen_at < 0) seen_at = k;
        got = if_m.word_o;
      end
    end
    check("hr_count", seen, 1);
    check("hr_when", seen_at, 15);
    check("hr_word", got, 8'hFF);
    half_rate = 1'b0;

    // enable gap of 5 cycles after bit 3 of 96
    v = 8'h96;
    for (int i = 7; i >= 5; i--) send_bit(v[i]);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      data = k[0];
      tick();
    end
    check("gap_valid", if_m.valid_o, 0);
    for (int i = 4; i >= 0; i--) send_bit(v[i]);
    check("gap_word_msb", if_m.word_o, 8'h96);
    check("gap_word_lsb", if_l.word_o, 8'h69);
    idle(1);

    // Overflow: 5 words into a depth-4 FIFO with ready low
    ready = 1'b0;
    exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
    for (int j = 0; j < 4; j++) send_byte(exp_q[j]);
    check("ovf_level_full", if_m.level_o, 4);
    check("ovf_not_yet", ovf_m, 0);
    send_byte(8'h55);
    check("ovf_level_held", if_m.level_o, 4);
    check("ovf_set", ovf_m, 1);
    check("ovf_set_lsb", ovf_l, 1);
    check("ovf_head_stable", if_m.word_o, 8'h11);
    enable = 1'b0;
    ready  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("ovf_pop_word", if_m.word_o, exp_q[j]);
      tick();
    end
    check("ovf_drained_valid", if_m.valid_o, 0);
    check("ovf_drained_level", if_l.level_o, 0);
    check("ovf_sticky", ovf_m, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_ovf", ovf_m, 0);

    // Full FIFO with push and pop on the same edge
    ready = 1'b0;
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    v = 8'hE5;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    ready = 1'b1;
    send_bit(v[0]);
    check("pp_level", if_m.level_o, 4);
    check("pp_ovf", ovf_m, 0);
    check("pp_head", if_m.word_o, 8'hB2);
    ready = 1'b0;

    // Async reset mid-word with a full FIFO
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_word", if_m.word_o, 0);
    check("arst_valid", if_m.valid_o, 0);
    check("arst_level", if_m.level_o, 0);
    check("arst_ovf", ovf_m, 0);
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    send_byte(8'h5A);
    check("post_rst_valid", if_m.valid_o, 1);
    check("post_rst_word", if_m.word_o, 8'h5A);
    check("post_rst_level", if_m.level_o, 1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
